// File: rtl/onehot_line_driver.sv
// One-hot line driver: 2-entry FIFO in front of an IDLE/DRIVE/GAP sequencer.
// Non-one-hot words are accepted, dropped and counted.
module onehot_line_driver #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_onehot,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [7:0]        line_en,
  output logic              busy,
  output logic              err_pulse,
  output logic [7:0]        err_count,
  output logic [2:0]        last_index
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [7:0]        mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] cnt;
  logic              ok;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              bad;
  logic [7:0]        head;
  logic [2:0]        head_idx;

  // No bypass: readiness follows occupancy only.
  assign in_ready = (count != 2'd2);
  assign ok   = (in_onehot != 8'd0) &&
                ((in_onehot & (in_onehot - 8'd1)) == 8'd0);
  assign xfer = in_valid & in_ready;
  assign push = xfer & ok;
  assign bad  = xfer & ~ok;
  assign pop  = (state == IDLE) && (count != 2'd0);
  assign head = mem[rd_ptr];

  always_comb begin
    head_idx = 3'd0;
    unique case (1'b1)
      head[1]: head_idx = 3'd1;
      head[2]: head_idx = 3'd2;
      head[3]: head_idx = 3'd3;
      head[4]: head_idx = 3'd4;
      head[5]: head_idx = 3'd5;
      head[6]: head_idx = 3'd6;
      head[7]: head_idx = 3'd7;
      default: head_idx = 3'd0;
    endcase
  end

  always_comb begin
    count_nxt = count + 2'(push) - 2'(pop);
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop) state_nxt = DRIVE;
      DRIVE:   if (cnt == '0) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]     <= 8'd0;
      mem[1]     <= 8'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      state      <= IDLE;
      cnt        <= '0;
      line_en    <= 8'd0;
      busy       <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= 8'd0;
      last_index <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_onehot;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count_nxt;
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE) || (count_nxt != 2'd0);
      err_pulse <= bad;
      if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
      unique case (state)
        IDLE: begin
          if (pop) begin
            line_en    <= head;
            cnt        <= hold_cycles;
            last_index <= head_idx;
          end else begin
            line_en <= 8'd0;
          end
        end
        DRIVE: begin
          if (cnt == '0) line_en <= 8'd0;
          else cnt <= cnt - 1'b1;
        end
        default: line_en <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_line_driver.sv
// Scoreboard bench for onehot_line_driver: stimulus queues expected drives,
// a negedge monitor checks every line_en pulse (word, length, index, gap).
module tb_onehot_line_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_onehot = 8'd0;
  logic [3:0] hold_cycles = 4'd0;
  logic [7:0] line_en;
  logic       busy;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [2:0] last_index;

  typedef struct {
    logic [7:0] w;
    int         len;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  onehot_line_driver #(.HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_onehot(in_onehot), .hold_cycles(hold_cycles),
    .line_en(line_en), .busy(busy),
    .err_pulse(err_pulse), .err_count(err_count),
    .last_index(last_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // monitor
  int         run = 0;
  int         zeros = 0;
  bit         seen = 0;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0; zeros = 0; seen = 0;
    end else if (line_en != 8'd0) begin
      if (run == 0) begin
        if (seen) chk("gap_ge2", 32'(zeros >= 2), 1);
        if (sb.size() == 0) begin
          chk("unexpected_line", {24'd0, line_en}, 0);
          cur = '{w: line_en, len: -1, idx: 3'd0};
        end else begin
          cur = sb.pop_front();
          chk("line_word", {24'd0, line_en}, {24'd0, cur.w});
          chk("last_index", {29'd0, last_index}, {29'd0, cur.idx});
        end
      end else if (line_en != cur.w) begin
        chk("line_stable", {24'd0, line_en}, {24'd0, cur.w});
      end
      run++;
      zeros = 0;
    end else begin
      if (run != 0) begin
        if (cur.len >= 0) chk("line_len", run, cur.len);
        seen = 1;
        run = 0;
      end
      zeros++;
    end
  end

  // expected index and length are supplied by the caller (hand-computed)
  task automatic send(input logic [7:0] w, input bit good,
                      input int len, input logic [2:0] idx);
    int k = 0;
    in_valid  = 1'b1;
    in_onehot = w;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 200) chk("send_timeout", 1, 0);
    @(posedge clk);
    if (good) sb.push_back('{w: w, len: len, idx: idx});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy || line_en != 0) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 500) chk("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_line();
    int k = 0;
    while (line_en == 8'd0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("line_timeout", 1, 0);
  endtask

  initial begin
    #2;
    chk("rst_line", {24'd0, line_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_errcnt", {24'd0, err_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T2 single word, hold 3 -> 4 cycles
    hold_cycles = 4'd3;
    send(8'h04, 1, 4, 3'd2);
    chk("t2_lat0", {24'd0, line_en}, 0);
    @(posedge clk); #1;
    chk("t2_lat1", {24'd0, line_en}, 8'h04);
    chk("t2_idx", {29'd0, last_index}, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_drop", {24'd0, line_en}, 0);
    chk("t2_busy_gap", {31'd0, busy}, 1);
    @(posedge clk); #1;
    chk("t2_busy_fall", {31'd0, busy}, 0);
    drain();

    // T3 back-to-back, hold 0
    hold_cycles = 4'd0;
    send(8'h01, 1, 1, 3'd0);
    send(8'h80, 1, 1, 3'd7);
    send(8'h10, 1, 1, 3'd4);
    chk("t3_full", {31'd0, in_ready}, 0);
    drain();

    // T4 invalid words
    send(8'h00, 0, 0, 3'd0);
    chk("t4_pulse0", {31'd0, err_pulse}, 1);
    send(8'h03, 0, 0, 3'd0);
    chk("t4_pulse1", {31'd0, err_pulse}, 1);
    send(8'hFF, 0, 0, 3'd0);
    chk("t4_pulse2", {31'd0, err_pulse}, 1);
    chk("t4_cnt3", {24'd0, err_count}, 3);
    @(posedge clk); #1;
    chk("t4_pulse_end", {31'd0, err_pulse}, 0);
    chk("t4_no_line", {24'd0, line_en}, 0);
    chk("t4_idle", {31'd0, busy}, 0);
    in_valid  = 1'b1;
    in_onehot = 8'h03;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t4_sat", {24'd0, err_count}, 255);
    chk("t4_no_line2", {24'd0, line_en}, 0);

    // T5 max hold, changed mid-drive
    hold_cycles = 4'hF;
    send(8'h20, 1, 16, 3'd5);
    wait_line();
    repeat (3) @(posedge clk);
    #1 hold_cycles = 4'd0;
    drain();

    // T6 full stall, then simultaneous push/pop
    hold_cycles = 4'd5;
    send(8'h02, 1, 6, 3'd1);
    wait_line();
    send(8'h04, 1, 6, 3'd2);
    send(8'h08, 1, 6, 3'd3);
    chk("t6_full", {31'd0, in_ready}, 0);
    in_valid  = 1'b1;
    in_onehot = 8'h40;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stall", {31'd0, in_ready}, 0);
    send(8'h40, 1, 6, 3'd6);
    drain();
    hold_cycles = 4'd2;
    send(8'h01, 1, 3, 3'd0);
    send(8'h02, 1, 3, 3'd1);
    chk("t6_cnt1", {31'd0, in_ready}, 1);
    chk("t6_busy", {31'd0, busy}, 1);
    drain();

    // T1 reset mid-drive with two words queued
    hold_cycles = 4'd7;
    send(8'h01, 1, 8, 3'd0);
    send(8'h02, 1, 8, 3'd1);
    send(8'h04, 1, 8, 3'd2);
    chk("t1_full", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    chk("t1_driving", {24'd0, line_en}, 8'h01);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t1_line", {24'd0, line_en}, 0);
    chk("t1_busy", {31'd0, busy}, 0);
    chk("t1_ready", {31'd0, in_ready}, 1);
    chk("t1_errcnt", {24'd0, err_count}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("t1_no_line", {24'd0, line_en}, 0);
    chk("t1_no_busy", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
